dmem_responder: RTL and testbench

- Multi-cycle data-memory responder on the target side of the MEM-stage load/store interface.
- Accepts one word request at a time from the pipeline and holds the pipeline with `stall` until the access completes.
- Answers with a one-cycle `resp_valid` pulse after a programmable access latency.
- Replaces the zero-latency data array so stall/hazard logic can be exercised against realistic memory timing.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 144 ++++++++++++++
 tb/tb_dmem_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the multi-cycle data-memory responder.
package dmem_pkg;

  localparam int WORD_W          = 32;
  localparam int DEFAULT_DEPTH   = 512;
  localparam int DEFAULT_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: whole array clears on reset, one synchronous
// write port and a combinational read port sharing the same index.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage: asynchronous clear of every word, otherwise write on we.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// Holds the pipeline with stall until the access completes, then pulses
// resp_valid for one cycle. Optional build macro DMEM_MISALIGN_TRAP_EN turns
// accesses with addr[1:0] != 0 into error responses with no array access.
//
// state | meaning
// IDLE  | no access in flight, accepting req_valid
// WAIT  | access captured, cnt counting down the extra latency
// DONE  | access committed on entry, resp_valid high this cycle
module dmem_responder
  import dmem_pkg::*;
#(
  parameter  int DEPTH   = DEFAULT_DEPTH,
  parameter  int LATENCY = DEFAULT_LATENCY,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall,
  output logic              busy
);

  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              capture, enter_done;
  logic              cap_we;
  logic [ADDR_W+1:0] cap_addr;
  logic [WORD_W-1:0] cap_wdata;
  logic              acc_we;
  logic [ADDR_W+1:0] acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic              misaligned;
  logic              arr_we;
  logic [WORD_W-1:0] arr_rdata;
  logic              unused_bits;

  // With zero latency the access commits on the accept edge, before the
  // capture registers are loaded, so IDLE reads the live request.
  assign acc_we    = (state == IDLE) ? req_we                : cap_we;
  assign acc_addr  = (state == IDLE) ? req_addr[ADDR_W+1:0]  : cap_addr;
  assign acc_wdata = (state == IDLE) ? req_wdata             : cap_wdata;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misaligned  = (acc_addr[1:0] != 2'b00);
  assign unused_bits = ^req_addr[31:ADDR_W+2];
`else
  assign misaligned  = 1'b0;
  assign unused_bits = ^{req_addr[31:ADDR_W+2], acc_addr[1:0]};
`endif

  assign arr_we     = enter_done & acc_we & ~misaligned;
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);
  assign stall      = req_valid & ~resp_valid;

  dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .addr  (acc_addr[ADDR_W+1:2]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  // State and latency down-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: accept in IDLE, count to terminal zero in WAIT.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    capture    = 1'b0;
    enter_done = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          if (LATENCY == 0) begin
            state_nxt  = DONE;
            enter_done = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = DONE;
          enter_done = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture; inputs are ignored once the access is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (capture) begin
      cap_we    <= req_we;
      cap_addr  <= req_addr[ADDR_W+1:0];
      cap_wdata <= req_wdata;
    end
  end

  // Response data/error load on entry to DONE and hold until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (enter_done) begin
      resp_err   <= misaligned;
      resp_rdata <= (acc_we || misaligned) ? '0 : arr_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=2 instance driven by a
// vector table plus hand sequences with a response scoreboard, and a
// LATENCY=0 instance exercised with back-to-back requests.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, stall, busy;
  logic [31:0] resp_rdata;

  logic        req_valid0, req_we0;
  logic [31:0] req_addr0, req_wdata0;
  logic        resp_valid0, resp_err0, stall0, busy0;
  logic [31:0] resp_rdata0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          start;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(512), .LATENCY(2)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .stall      (stall),
    .busy       (busy)
  );

  dmem_responder #(.DEPTH(512), .LATENCY(0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid0),
    .req_we     (req_we0),
    .req_addr   (req_addr0),
    .req_wdata  (req_wdata0),
    .resp_valid (resp_valid0),
    .resp_rdata (resp_rdata0),
    .resp_err   (resp_err0),
    .stall      (stall0),
    .busy       (busy0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", resp_err, e.err);
        chk("resp_latency", cyc - e.start, 3);
      end
    end
  end

  // Drive one request (called just after a rising edge), wait for its pulse,
  // and release req_valid on the edge that ends the response cycle.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input string tag, output int rc);
    int n;
    rc = -1;
    n  = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    sb.push_back('{exp_rdata, exp_err, cyc});
    @(negedge clk);
    while (!resp_valid && n < 40) begin
      chk({tag, "_stall_hi"}, stall, 1);
      @(negedge clk);
      n++;
    end
    if (!resp_valid) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      chk({tag, "_stall_lo"}, stall, 0);
      rc = cyc;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, rc_prev;
    logic [31:0] l0_addr[4];
    logic [31:0] l0_data[4];
    logic        l0_we[4];
    logic        mis_err;
    logic [31:0] mis_word;

    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,          32'h0};
    vecs[1] = '{1'b1, 32'h0000_0020, 32'hDEAD_BEEF,  32'h0};
    vecs[2] = '{1'b0, 32'h0000_0020, 32'h0,          32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 32'h0000_0800, 32'h1234_5678,  32'h0};
    vecs[4] = '{1'b0, 32'h0000_0000, 32'h0,          32'h1234_5678};
    vecs[5] = '{1'b1, 32'h0000_07FC, 32'hA5A5_0001,  32'h0};
    vecs[6] = '{1'b0, 32'h0000_0FFC, 32'h0,          32'hA5A5_0001};
    vecs[7] = '{1'b0, 32'h0000_1004, 32'h0,          32'h0};

    l0_we   = '{1'b1, 1'b0, 1'b1, 1'b0};
    l0_addr = '{32'h8, 32'h8, 32'hC, 32'hC};
    l0_data = '{32'h0BAD_F00D, 32'h0, 32'h3, 32'h0};

    rst = 1'b1;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    req_valid0 = 0; req_we0 = 0; req_addr0 = 0; req_wdata0 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_busy0", busy0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // LATENCY=0: a new request every other cycle, req_valid held high.
    req_valid0 = 1'b1;
    req_we0 = l0_we[0]; req_addr0 = l0_addr[0]; req_wdata0 = l0_data[0];
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("l0_resp_valid", resp_valid0, k % 2);
      chk("l0_busy", busy0, k % 2);
      chk("l0_stall", stall0, (k % 2 == 0) ? 1 : 0);
      if (k == 3) chk("l0_rdata_t1", resp_rdata0, 32'h0BAD_F00D);
      if (k == 7) chk("l0_rdata_t3", resp_rdata0, 32'h3);
      @(posedge clk);
      #1;
      if (k % 2 == 1 && k < 7) begin
        req_we0 = l0_we[(k + 1) / 2];
        req_addr0 = l0_addr[(k + 1) / 2];
        req_wdata0 = l0_data[(k + 1) / 2];
      end
    end
    req_valid0 = 1'b0;

    // Table of back-to-back accesses at LATENCY=2, including wrap cases.
    rc_prev = -1;
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1'b0, $sformatf("vec%0d", i), rc);
      if (i == 2) chk("pulse_spacing", rc - rc_prev, 4);
      rc_prev = rc;
    end

    // req_valid drops mid-store and inputs change: store still commits.
    req_valid = 1; req_we = 1; req_addr = 32'h30; req_wdata = 32'hCAFE_0000;
    sb.push_back('{32'h0, 1'b0, cyc});
    @(negedge clk);
    chk("drop_stall_c0", stall, 1);
    @(posedge clk);
    #1;
    req_valid = 0; req_we = 0; req_addr = 32'h34; req_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("drop_stall_c1", stall, 0);
    chk("drop_busy_c1", busy, 1);
    rc = 0;
    while (!resp_valid && rc < 10) begin
      @(negedge clk);
      rc++;
    end
    chk("drop_resp_seen", resp_valid, 1);
    @(posedge clk);
    #1;
    issue(1'b0, 32'h34, 32'h0, 32'h0, 1'b0, "drop_ld34", rc);
    issue(1'b0, 32'h30, 32'h0, 32'hCAFE_0000, 1'b0, "drop_ld30", rc);
    repeat (2) @(negedge clk);
    chk("rdata_hold", resp_rdata, 32'hCAFE_0000);
    chk("idle_busy", busy, 0);
    @(posedge clk);
    #1;

    // Reset during WAIT of a store: no response, store discarded, array cleared.
    req_valid = 1; req_we = 1; req_addr = 32'h40; req_wdata = 32'h1111_1111;
    @(posedge clk);
    #1;
    chk("rst_mid_busy_before", busy, 1);
    req_valid = 0;
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rdata", resp_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rst_mid_no_resp", resp_valid, 0);
    end
    @(posedge clk);
    #1;
    issue(1'b0, 32'h40, 32'h0, 32'h0, 1'b0, "rst_ld40", rc);
    issue(1'b0, 32'h20, 32'h0, 32'h0, 1'b0, "rst_ld20", rc);

    // Misaligned store to word 8.
`ifdef DMEM_MISALIGN_TRAP_EN
    mis_err  = 1'b1;
    mis_word = 32'h0000_0077;
`else
    mis_err  = 1'b0;
    mis_word = 32'h55AA_55AA;
`endif
    issue(1'b1, 32'h20, 32'h77, 32'h0, 1'b0, "mis_pre", rc);
    issue(1'b1, 32'h22, 32'h55AA_55AA, 32'h0, mis_err, "mis_st", rc);
    issue(1'b0, 32'h20, 32'h0, mis_word, 1'b0, "mis_ld", rc);
`ifdef DMEM_MISALIGN_TRAP_EN
    issue(1'b0, 32'h23, 32'h0, 32'h0, 1'b1, "mis_ld23", rc);
`else
    issue(1'b0, 32'h23, 32'h0, 32'h55AA_55AA, 1'b0, "mis_ld23", rc);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
